// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// State encoding, requester ids and the minimum legal memory latency.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int MEM_LAT_MIN = 1;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and data requesters.
// Data wins ties unless fetch has been passed over STARVE_MAX times.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic if_valid,
    input  logic d_valid,
    output logic grant,
    output logic grant_id
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (STARVE_MAX > 0) && (starve_cnt == CNT_MAX);

    always_comb begin
        grant    = enable && (if_valid || d_valid);
        grant_id = REQ_IF;
        if (d_valid && !(if_valid && starved)) begin
            grant_id = REQ_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_id == REQ_D && if_valid) begin
                // saturate so a zero guard never wraps
                if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and load/store, one access at a time.
// Optional perf counters are built when MEMARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rdata,
`ifdef MEMARB_PERF_EN
    output logic [15:0]       perf_if_grants,
    output logic [15:0]       perf_d_grants,
    output logic [15:0]       perf_if_stall,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN : MEM_LAT;
    localparam int LAT_W   = $clog2(LAT_EFF + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT_EFF - 1);

    state_t            state;
    state_t            state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              idle;
    logic              grant;
    logic              grant_id;

    logic              cap_id;
    logic              cap_we;
    logic [3:0]        cap_be;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;

    // reset masks the grant so readys stay low while rst_n is asserted
    assign idle = (state == IDLE) && rst_n;

    mem_arb_grant #(
        .STARVE_MAX(STARVE_MAX)
    ) u_grant (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (idle),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign if_req_ready = grant && (grant_id == REQ_IF);
    assign d_req_ready  = grant && (grant_id == REQ_D);

    always_comb begin
        state_nxt    = state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = cap_we;
                mem_be    = cap_be;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                if_rsp_valid = (cap_id == REQ_IF);
                d_rsp_valid  = (cap_id == REQ_D);
                state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt   <= '0;
            cap_id    <= REQ_IF;
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant) begin
                cap_id <= grant_id;
                if (grant_id == REQ_D) begin
                    cap_we    <= d_we;
                    cap_be    <= d_we ? d_be : 4'b0000;
                    cap_addr  <= d_addr;
                    cap_wdata <= d_wdata;
                end else begin
                    cap_we    <= 1'b0;
                    cap_be    <= '0;
                    cap_addr  <= if_addr;
                    cap_wdata <= '0;
                end
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (state == WAIT && lat_cnt == '0) begin
                if (cap_id == REQ_D) d_rdata <= cap_we ? 32'h0 : mem_rdata;
                else                 if_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_if_stall  <= '0;
        end else begin
            if (if_req_ready && perf_if_grants != 16'hFFFF)
                perf_if_grants <= perf_if_grants + 1'b1;
            if (d_req_ready && perf_d_grants != 16'hFFFF)
                perf_d_grants <= perf_d_grants + 1'b1;
            if (if_req_valid && !if_req_ready && perf_if_stall != 16'hFFFF)
                perf_if_stall <= perf_if_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a timeline model.
// A second instance with STARVE_MAX=0 checks strict data priority.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        if_req_ready0, d_req_ready0;
    logic        if_rsp_valid0, d_rsp_valid0;
    logic [31:0] if_rdata0, d_rdata0;
    logic        mem_en0, mem_we0;
    logic [3:0]  mem_be0;
    logic [31:0] mem_addr0, mem_wdata0;
`ifdef MEMARB_PERF_EN
    logic [15:0] perf_if_grants, perf_d_grants, perf_if_stall;
    logic [15:0] perf_if_grants0, perf_d_grants0, perf_if_stall0;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
        .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
        .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid),
        .d_rdata(d_rdata),
`ifdef MEMARB_PERF_EN
        .perf_if_grants(perf_if_grants),
        .perf_d_grants(perf_d_grants),
        .perf_if_stall(perf_if_stall),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .ADDR_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready0),
        .if_addr(if_addr), .if_rsp_valid(if_rsp_valid0),
        .if_rdata(if_rdata0),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready0),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
        .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid0),
        .d_rdata(d_rdata0),
`ifdef MEMARB_PERF_EN
        .perf_if_grants(perf_if_grants0),
        .perf_d_grants(perf_d_grants0),
        .perf_if_stall(perf_if_stall0),
`endif
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_be(mem_be0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // timeline model: one transaction, known issue/response cycles
    int          free_cyc = 0;
    int          issue_cyc = -1;
    int          resp_cyc = -1;
    int          starve = 0;
    logic        t_id;
    logic        t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] m_if_rdata = 0, m_d_rdata = 0;
    logic        acc_if, acc_d;
    logic        rnd_mode = 0, hold_mode = 0, log_en = 0;

    // observations of the DUT, used for hand-computed literal checks
    int          hs_if, hs_d, rsp_if, rsp_d, mem_cyc;
    int          n_if_rsp = 0;
    logic [31:0] obs_if_rdata, obs_d_rdata, obs_addr, obs_wdata;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [9:0]  glog;
    int          ng = 0, n0d = 0, n0i = 0;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic g_d, g_if, e_en, e_ifr, e_dr;
        g_d = 0; g_if = 0; e_en = 0; e_ifr = 0; e_dr = 0;
        if (issue_cyc >= 0 && cyc == issue_cyc + MEM_LAT)
            mem_rdata = pattern(t_addr);
        else
            mem_rdata = $urandom;
        if (!rst_n) begin
            issue_cyc = -1; resp_cyc = -1; free_cyc = 0; starve = 0;
            m_if_rdata = 0; m_d_rdata = 0;
        end else begin
            if (cyc >= free_cyc) begin
                g_d = d_req_valid && !(if_req_valid && STARVE_MAX > 0
                                       && starve == STARVE_MAX);
                g_if = if_req_valid && !g_d;
            end
            e_en = (cyc == issue_cyc);
            if (cyc == resp_cyc) begin
                if (t_id) begin
                    e_dr = 1;
                    m_d_rdata = t_we ? 32'h0 : pattern(t_addr);
                end else begin
                    e_ifr = 1;
                    m_if_rdata = pattern(t_addr);
                end
            end
        end
        @(negedge clk);
        chk("if_req_ready", if_req_ready, g_if);
        chk("d_req_ready", d_req_ready, g_d);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_we", mem_we, t_we);
            chk("mem_be", mem_be, t_be);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        if (!rst_n) begin
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
        chk("if_rsp_valid", if_rsp_valid, e_ifr);
        chk("d_rsp_valid", d_rsp_valid, e_dr);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (if_req_valid && if_req_ready) begin
            hs_if = cyc;
            if (log_en && ng < 10) begin glog = {glog[8:0], 1'b1}; ng++; end
        end
        if (d_req_valid && d_req_ready) begin
            hs_d = cyc;
            if (log_en && ng < 10) begin glog = {glog[8:0], 1'b0}; ng++; end
        end
        if (log_en) begin
            if (if_req_valid && if_req_ready0) n0i++;
            if (d_req_valid && d_req_ready0) n0d++;
        end
        if (if_rsp_valid) begin
            rsp_if = cyc; obs_if_rdata = if_rdata; n_if_rsp++;
        end
        if (d_rsp_valid) begin rsp_d = cyc; obs_d_rdata = d_rdata; end
        if (mem_en) begin
            mem_cyc = cyc; obs_addr = mem_addr; obs_we = mem_we;
            obs_be = mem_be; obs_wdata = mem_wdata;
        end
        if (g_d) begin
            t_id = 1; t_addr = d_addr; t_we = d_we;
            t_be = d_we ? d_be : 4'b0; t_wdata = d_wdata;
            starve = if_req_valid ? starve + 1 : 0;
        end
        if (g_if) begin
            t_id = 0; t_addr = if_addr; t_we = 0; t_be = 0; t_wdata = 0;
            starve = 0;
        end
        if (g_d || g_if) begin
            issue_cyc = cyc + 1;
            resp_cyc  = cyc + 2 + MEM_LAT;
            free_cyc  = cyc + 3 + MEM_LAT;
        end
        acc_if = g_if;
        acc_d  = g_d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (rnd_mode) begin
                if (!if_req_valid && $urandom_range(0, 2) != 0) begin
                    if_req_valid = 1;
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
                if (!d_req_valid && $urandom_range(0, 2) != 0) begin
                    d_req_valid = 1;
                    d_addr  = $urandom;
                    d_we    = 1'($urandom);
                    d_be    = 4'($urandom);
                    d_wdata = $urandom;
                end
            end
            step();
            if (acc_if && !hold_mode) if_req_valid = 0;
            if (acc_d && !hold_mode) d_req_valid = 0;
        end
    endtask

    initial begin
        rst_n = 0; if_req_valid = 0; if_addr = 0;
        d_req_valid = 0; d_addr = 0; d_we = 0; d_be = 0; d_wdata = 0;
        mem_rdata = 0;
        @(posedge clk); #1;
        run(3);

        // release with a fetch waiting: ready in the first cycle
        if_req_valid = 1; if_addr = 32'h10; rst_n = 1;
        run(1);
        chk("first_fetch_hs", hs_if, cyc - 1);
        run(5);
        chk("fetch_mem_lat", mem_cyc - hs_if, 1);
        chk("fetch_mem_addr", obs_addr, 32'h10);
        chk("fetch_rsp_lat", rsp_if - hs_if, 4);
        chk("fetch_rdata", obs_if_rdata, 32'h00500093);

        // simultaneous fetch and load
        if_req_valid = 1; if_addr = 32'h0;
        d_req_valid = 1; d_addr = 32'h100; d_we = 0;
        run(11);
        chk("sim_d_rsp", rsp_d - hs_d, 4);
        chk("sim_if_hs", hs_if - hs_d, 5);
        chk("sim_if_rsp", rsp_if - hs_d, 9);
        chk("sim_d_rdata", obs_d_rdata, pattern(32'h100));

        // store
        d_req_valid = 1; d_addr = 32'h104; d_we = 1;
        d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
        run(6);
        chk("st_mem_cyc", mem_cyc - hs_d, 1);
        chk("st_mem_we", obs_we, 1);
        chk("st_mem_be", obs_be, 4'b0011);
        chk("st_mem_wdata", obs_wdata, 32'hDEADBEEF);
        chk("st_rsp_lat", rsp_d - hs_d, 4);
        chk("st_rdata", obs_d_rdata, 0);

        rnd_mode = 1;
        run(600);
        rnd_mode = 0;
        if_req_valid = 0; d_req_valid = 0;
        run(6);

        // starvation guard with both requesters always valid
        rst_n = 0;
        run(3);
        if_req_valid = 1; if_addr = 32'h40;
        d_req_valid = 1; d_addr = 32'h200; d_we = 0;
        hold_mode = 1; log_en = 1; rst_n = 1;
        run(50);
        log_en = 0; hold_mode = 0;
        chk("starve_count", ng, 10);
        chk("starve_order", glog, 10'b0000100001);
        chk("strict_d_grants", n0d, 10);
        chk("strict_if_grants", n0i, 0);
        if_req_valid = 0; d_req_valid = 0;
        run(6);

        // reset in the middle of a fetch, during ISSUE and during WAIT
        for (int k = 1; k <= 2; k++) begin
            int n_before;
            if_req_valid = 1; if_addr = 32'h10;
            run(1);
            run(k - 1);
            n_before = n_if_rsp;
            rst_n = 0;
            run(3);
            rst_n = 1;
            run(5);
            chk("mid_rst_no_rsp", n_if_rsp, n_before);
            if_req_valid = 1; if_addr = 32'h10;
            run(6);
            chk("post_rst_rsp_lat", rsp_if - hs_if, 4);
            chk("post_rst_rdata", obs_if_rdata, 32'h00500093);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
